// File: rtl/instr_fetch_pkg.sv
// ---------------------------------------------------------------------------
// instr_fetch_pkg
// Shared CPU definitions used by the fetch stage and its neighbours:
//   - fetch_state_e : fetch FSM states (IDLE, REQ, HOLD)
//   - OP_*          : primary opcode values (instr[31:26])
//   - DEFAULT_RESET_PC : byte address of the first instruction after reset
// ---------------------------------------------------------------------------
package instr_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } fetch_state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_if
// Instruction-memory request/acknowledge bus.
//   imem_req   : fetch request (fetch unit -> memory)
//   imem_addr  : word-aligned byte address (fetch unit -> memory)
//   imem_ack   : data returned this cycle (memory -> fetch unit)
//   imem_rdata : instruction word, valid with imem_ack (memory -> fetch unit)
// Modports: master = fetch unit, slave = instruction memory.
// ---------------------------------------------------------------------------
interface instr_fetch_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/instr_fetch_next_pc.sv
// ---------------------------------------------------------------------------
// instr_fetch_next_pc
// Purely combinational next-PC selection for the fetch stage.
//   pc_plus4   in  ADDR_W : address of the sequential successor
//   instr_low  in  26     : instr[25:0] of the retiring instruction
//   branch     in  1      : BEQ decoded
//   zero       in  1      : ALU zero flag
//   jump       in  1      : J decoded (wins over branch)
//   next_pc    out ADDR_W : address of the next instruction to fetch
// ---------------------------------------------------------------------------
module instr_fetch_next_pc #(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] pc_plus4,
    input  logic [25:0]       instr_low,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [ADDR_W-1:0] next_pc
);

    logic signed [ADDR_W-1:0] br_offset;
    logic signed [ADDR_W-1:0] br_target;
    logic        [ADDR_W-1:0] j_target;

    // Word offset sign-extended and scaled to bytes in a single concatenation.
    assign br_offset = {{(ADDR_W-18){instr_low[15]}}, instr_low[15:0], 2'b00};
    // Wraps modulo 2^ADDR_W by construction of the fixed-width add.
    assign br_target = $signed(pc_plus4) + br_offset;
    // Jump keeps the upper region bits of the sequential successor.
    assign j_target  = {pc_plus4[ADDR_W-1:28], instr_low, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = j_target;
        end else if (branch && zero) begin
            next_pc = br_target;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// ---------------------------------------------------------------------------
// instr_fetch
// Single-outstanding-request instruction fetch stage. After reset it idles
// one cycle, requests the word at pc, holds the returned instruction until
// the core retires it (advance), then requests the next PC.
//   clk, rst_n   : clock, asynchronous active-low reset
//   imem         : instruction-memory bus (master side)
//   instr_valid  : instr/op/funct/pc hold a fetched instruction
//   instr        : current instruction word
//   op, funct    : instr[31:26], instr[5:0]
//   pc, pc_plus4 : address of current instruction and its successor
//   advance      : current instruction retires this cycle
//   branch, zero, jump : next-PC controls, used only when retiring
//   retired_cnt  : free-running count of retired instructions
// ---------------------------------------------------------------------------
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk,
    input  logic              rst_n,
    instr_fetch_if.master     imem,
    output logic              instr_valid,
    output logic [31:0]       instr,
    output logic [5:0]        op,
    output logic [5:0]        funct,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              advance,
    input  logic              branch,
    input  logic              zero,
    input  logic              jump,
    output logic [31:0]       retired_cnt
);

    localparam logic [ADDR_W-1:0] PC_RST = {RESET_PC[ADDR_W-1:2], 2'b00};

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic [31:0]       retired_cnt_q, retired_cnt_d;
    logic [ADDR_W-1:0] next_pc;

    instr_fetch_next_pc #(
        .ADDR_W (ADDR_W)
    ) u_next_pc (
        .pc_plus4  (pc_plus4),
        .instr_low (instr_q[25:0]),
        .branch    (branch),
        .zero      (zero),
        .jump      (jump),
        .next_pc   (next_pc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            pc_q          <= PC_RST;
            instr_q       <= 32'h0;
            instr_valid_q <= 1'b0;
            retired_cnt_q <= 32'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            retired_cnt_q <= retired_cnt_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        retired_cnt_d = retired_cnt_q;

        unique case (state_q)
            IDLE: begin
                state_d = REQ;
            end
            REQ: begin
                if (imem.imem_ack) begin
                    instr_d       = imem.imem_rdata;
                    instr_valid_d = 1'b1;
                    state_d       = HOLD;
                end
            end
            HOLD: begin
                // instr_valid is always set in HOLD, so advance is honoured
                // only while an instruction is actually presented.
                if (advance && instr_valid_q) begin
                    pc_d          = {next_pc[ADDR_W-1:2], 2'b00};
                    instr_valid_d = 1'b0;
                    retired_cnt_d = retired_cnt_q + 32'd1;
                    state_d       = REQ;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Request is a pure function of state so reset drops it without a clock.
    assign imem.imem_req  = (state_q == REQ);
    assign imem.imem_addr = pc_q;

    assign instr_valid = instr_valid_q;
    assign instr       = instr_q;
    assign op          = instr_q[31:26];
    assign funct       = instr_q[5:0];
    assign pc          = pc_q;
    assign pc_plus4    = pc_q + {{(ADDR_W-3){1'b0}}, 3'd4};
    assign retired_cnt = retired_cnt_q;

endmodule

// File: tb/tb_instr_fetch.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch
// Self-checking bench for instr_fetch: directed scenarios with literal
// expectations followed by randomized traffic, all compared every cycle
// against a transaction-level model of the fetch stage.
// ---------------------------------------------------------------------------
module tb_instr_fetch;

    localparam int ADDR_W = 32;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        advance;
    logic        branch;
    logic        zero;
    logic        jump;
    logic [31:0] retired_cnt;

    int n_cmp;
    int n_err;

    instr_fetch_if #(.ADDR_W(ADDR_W)) bus ();

    instr_fetch #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem        (bus),
        .instr_valid (instr_valid),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .pc          (pc),
        .pc_plus4    (pc_plus4),
        .advance     (advance),
        .branch      (branch),
        .zero        (zero),
        .jump        (jump),
        .retired_cnt (retired_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The fetch stage is one of: just out of reset, waiting on memory,
    // or presenting an instruction.
    logic        m_started;
    logic        m_valid;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_cnt;

    function automatic logic [31:0] model_next_pc(input logic [31:0] cur_pc,
                                                  input logic [31:0] iw,
                                                  input logic b, input logic z,
                                                  input logic j);
        longint seq;
        longint off;
        seq = longint'(cur_pc) + 4;
        if (j)
            return (32'(seq) & 32'hF000_0000) | (32'(iw[25:0]) * 32'd4);
        if (b && z) begin
            off = longint'($signed(iw[15:0])) * 4;
            return 32'(seq + off);
        end
        return 32'(seq);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_started <= 1'b0;
            m_valid   <= 1'b0;
            m_pc      <= 32'h0;
            m_instr   <= 32'h0;
            m_cnt     <= 32'h0;
        end else if (!m_started) begin
            m_started <= 1'b1;
        end else if (!m_valid) begin
            if (bus.imem_ack) begin
                m_valid <= 1'b1;
                m_instr <= bus.imem_rdata;
            end
        end else if (advance) begin
            m_pc    <= model_next_pc(m_pc, m_instr, branch, zero, jump);
            m_valid <= 1'b0;
            m_cnt   <= m_cnt + 32'd1;
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("m_req",   {31'd0, bus.imem_req}, {31'd0, m_started && !m_valid});
        chk("m_valid", {31'd0, instr_valid},  {31'd0, m_valid});
        chk("m_pc",    pc,          m_pc);
        chk("m_addr",  bus.imem_addr, m_pc);
        chk("m_pc4",   pc_plus4,    m_pc + 32'd4);
        chk("m_instr", instr,       m_instr);
        chk("m_op",    {26'd0, op},    {26'd0, m_instr[31:26]});
        chk("m_funct", {26'd0, funct}, {26'd0, m_instr[5:0]});
        chk("m_cnt",   retired_cnt, m_cnt);
    end

    // Drive one cycle of inputs (from a negedge) and land on the next negedge.
    task automatic step(input logic adv, input logic br, input logic z,
                        input logic j, input logic ack, input logic [31:0] rd);
        advance        = adv;
        branch         = br;
        zero           = z;
        jump           = j;
        bus.imem_ack   = ack;
        bus.imem_rdata = rd;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step(0, 0, 0, 0, 0, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        rst_n = 1'b1;
    endtask

    // Fetch a word (REQ with ack) and retire it sequentially.
    task automatic fetch_and_retire(input logic [31:0] word);
        step(0, 0, 0, 0, 1, word);
        step(1, 0, 0, 0, 0, 32'h0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        advance = 0; branch = 0; zero = 0; jump = 0;
        bus.imem_ack = 0; bus.imem_rdata = 32'h0;
        @(negedge clk);
        @(negedge clk);

        // Reset values, including combinational pc_plus4.
        chk("rst_req",   {31'd0, bus.imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc",    pc, 32'h0);
        chk("rst_pc4",   pc_plus4, 32'h4);
        chk("rst_cnt",   retired_cnt, 32'h0);

        // First fetch with ack tied high.
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 32'h3408_0005);   // IDLE cycle
        chk("f1_req",  {31'd0, bus.imem_req}, 32'd1);
        chk("f1_addr", bus.imem_addr, 32'h0);
        chk("f1_vld0", {31'd0, instr_valid}, 32'd0);
        step(0, 0, 0, 0, 1, 32'h3408_0005);   // REQ sees ack
        chk("f1_vld",  {31'd0, instr_valid}, 32'd1);
        chk("f1_op",   {26'd0, op}, 32'h0D);
        chk("f1_pc",   pc, 32'h0);
        chk("f1_req0", {31'd0, bus.imem_req}, 32'd0);

        // Sequential advance.
        step(1, 0, 0, 0, 0, 32'h0);
        chk("seq_addr", bus.imem_addr, 32'h4);
        chk("seq_cnt",  retired_cnt, 32'd1);
        chk("seq_req",  {31'd0, bus.imem_req}, 32'd1);

        // Wait states: request stays stable.
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, 32'hFFFF_FFFF);
            chk("ws_req",  {31'd0, bus.imem_req}, 32'd1);
            chk("ws_addr", bus.imem_addr, 32'h4);
        end
        step(0, 0, 0, 0, 1, 32'h0);
        chk("ws_vld", {31'd0, instr_valid}, 32'd1);
        chk("ws_pc",  pc, 32'h4);
        // advance while valid=0 is ignored: hold it across a REQ cycle
        step(1, 0, 0, 0, 0, 32'h0);            // retire -> pc 8
        step(1, 0, 0, 0, 0, 32'h0);            // REQ, advance ignored
        chk("advign_cnt", retired_cnt, 32'd2);
        chk("advign_req", {31'd0, bus.imem_req}, 32'd1);

        // BEQ taken at pc=8.
        step(0, 0, 0, 0, 1, 32'h1000_FFFE);
        step(1, 1, 1, 0, 0, 32'h0);
        chk("beq_t_addr", bus.imem_addr, 32'h4);
        chk("beq_t_cnt",  retired_cnt, 32'd3);
        fetch_and_retire(32'h0);               // 4 -> 8
        // BEQ not taken at pc=8.
        step(0, 0, 0, 0, 1, 32'h1000_FFFE);
        step(1, 1, 0, 0, 0, 32'h0);
        chk("beq_n_addr", bus.imem_addr, 32'hC);
        fetch_and_retire(32'h0);               // 12 -> 16
        chk("pre_j_addr", bus.imem_addr, 32'h10);
        // Jump has priority.
        step(0, 0, 0, 0, 1, 32'h0800_0100);
        step(1, 1, 1, 1, 0, 32'h0);
        chk("jmp_addr", bus.imem_addr, 32'h400);
        chk("jmp_cnt",  retired_cnt, 32'd7);

        // PC wrap: branch back from 0 lands on FFFF_FFFC, then wraps to 0.
        do_reset();
        step(0, 0, 0, 0, 0, 32'h0);            // IDLE
        step(0, 0, 0, 0, 1, 32'h1000_FFFE);
        step(1, 1, 1, 0, 0, 32'h0);
        chk("wrap_hi", bus.imem_addr, 32'hFFFF_FFFC);
        chk("wrap_p4", pc_plus4, 32'h0);
        fetch_and_retire(32'h0);
        chk("wrap_lo", bus.imem_addr, 32'h0);

        // Reset during REQ; ack during IDLE after release is ignored.
        #2 rst_n = 1'b0;
        #1;
        chk("mid_req", {31'd0, bus.imem_req}, 32'd0);
        chk("mid_cnt", retired_cnt, 32'd0);
        chk("mid_pc",  pc, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 0, 0, 1, 32'hDEAD_BEEF);    // IDLE, ack ignored
        chk("mid_vld0", {31'd0, instr_valid}, 32'd0);
        chk("mid_req1", {31'd0, bus.imem_req}, 32'd1);
        chk("mid_addr", bus.imem_addr, 32'h0);
        step(0, 0, 0, 0, 0, 32'h0);
        chk("mid_vld1", {31'd0, instr_valid}, 32'd0);
        chk("mid_instr", instr, 32'h0);

        // Randomized traffic checked by the model.
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 249) == 0) begin
                #2 rst_n = 1'b0;
                #1;
                chk("rnd_rst_req", {31'd0, bus.imem_req}, 32'd0);
                chk("rnd_rst_pc",  pc, 32'h0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0),
                 1'($urandom_range(0, 2) != 0), $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
